// File: rtl/cache_mem_responder.sv
// Backing-memory responder for a 4-word-line cache: line refills and write-backs with fixed latency.
// Optional build macro REFILL_CWF_EN: refill starts at the requested word and wraps (critical word first).
module cache_mem_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refill_req,
  input  logic [63:0] refill_addr,
  input  logic        wb_req,
  input  logic [63:0] wb_addr,
  input  logic [63:0] write_data,
  output logic [63:0] refill_data,
  output logic        refill_valid,
  output logic [1:0]  refill_beat,
  output logic        refilled,
  output logic        wb_data_ready,
  output logic        write_finish,
  output logic        busy
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned LW  = AW - 2;
  localparam logic [3:0]  LAT = 4'(LATENCY);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_BURST, RD_DONE, WB_DATA, WB_WAIT, WB_DONE
  } state_t;

  state_t        state;
  logic [63:0]   mem [DEPTH_WORDS];
  logic [LW-1:0] line_q;
  logic [1:0]    first_q;
  logic [1:0]    beat_cnt;
  logic [3:0]    wait_cnt;
  logic [1:0]    req_first;
  logic [1:0]    next_beat;
  logic          unused_addr_bits;

`ifdef REFILL_CWF_EN
  assign req_first = refill_addr[4:3];
`else
  assign req_first = 2'd0;
`endif

  assign next_beat = refill_beat + 2'd1;

  // Byte offset, in-line word offset and bits above the storage range carry no line information.
  assign unused_addr_bits = ^{refill_addr[63:AW+3], refill_addr[4:0],
                              wb_addr[63:AW+3], wb_addr[4:0]};

  // Write-back beats land in storage as they arrive; storage is never reset.
  always_ff @(posedge clk) begin
    if (state == WB_DATA) mem[{line_q, beat_cnt}] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      line_q        <= '0;
      first_q       <= 2'd0;
      beat_cnt      <= 2'd0;
      wait_cnt      <= 4'd0;
      refill_data   <= 64'd0;
      refill_valid  <= 1'b0;
      refill_beat   <= 2'd0;
      refilled      <= 1'b0;
      wb_data_ready <= 1'b0;
      write_finish  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      refilled     <= 1'b0;
      write_finish <= 1'b0;
      case (state)
        IDLE: begin
          // Write-back wins so a same-line refill observes the evicted data.
          if (wb_req) begin
            state         <= WB_DATA;
            line_q        <= wb_addr[5 +: LW];
            beat_cnt      <= 2'd0;
            wb_data_ready <= 1'b1;
            busy          <= 1'b1;
          end else if (refill_req) begin
            line_q   <= refill_addr[5 +: LW];
            first_q  <= req_first;
            beat_cnt <= 2'd0;
            busy     <= 1'b1;
            if (LAT == 4'd0) begin
              state        <= RD_BURST;
              refill_valid <= 1'b1;
              refill_beat  <= req_first;
              refill_data  <= mem[{refill_addr[5 +: LW], req_first}];
            end else begin
              state    <= RD_WAIT;
              wait_cnt <= 4'(LAT - 4'd1);
            end
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state        <= RD_BURST;
            refill_valid <= 1'b1;
            refill_beat  <= first_q;
            refill_data  <= mem[{line_q, first_q}];
          end else begin
            wait_cnt <= 4'(wait_cnt - 4'd1);
          end
        end
        RD_BURST: begin
          if (beat_cnt == 2'd3) begin
            state        <= RD_DONE;
            refill_valid <= 1'b0;
            refill_beat  <= 2'd0;
            refill_data  <= 64'd0;
            refilled     <= 1'b1;
          end else begin
            beat_cnt    <= 2'(beat_cnt + 2'd1);
            refill_beat <= next_beat;
            refill_data <= mem[{line_q, next_beat}];
          end
        end
        RD_DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        WB_DATA: begin
          if (beat_cnt == 2'd3) begin
            wb_data_ready <= 1'b0;
            if (LAT == 4'd0) begin
              state        <= WB_DONE;
              write_finish <= 1'b1;
            end else begin
              state    <= WB_WAIT;
              wait_cnt <= 4'(LAT - 4'd1);
            end
          end else begin
            beat_cnt <= 2'(beat_cnt + 2'd1);
          end
        end
        WB_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state        <= WB_DONE;
            write_finish <= 1'b1;
          end else begin
            wait_cnt <= 4'(wait_cnt - 4'd1);
          end
        end
        WB_DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL provide parameter LATENCY, default 4, meaning the number of wait cycles before the first read beat or before write completion (0..15).
REQ-002 SHALL provide parameter DEPTH_WORDS, default 1024, meaning the number of 64-bit words of backing storage (power of two).
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 refill_req  input  1  cache requests a line fill; held until refilled.
REQ-006 refill_addr  input  64  byte address of the missing word.
REQ-007 wb_req  input  1  cache requests a line write-back; held until write_finish.
REQ-008 wb_addr  input  64  byte address of the victim line.
REQ-009 write_data  input  64  write-back beat data, consumed while wb_data_ready=1.
REQ-010 refill_data  output  64  read beat data.
REQ-011 refill_valid  output  1  refill_data and refill_beat are valid this cycle.
REQ-012 refill_beat  output  2  word index within the line of the current read beat.
REQ-013 refilled  output  1  one-cycle pulse: line fill complete.
REQ-014 wb_data_ready  output  1  write_data is captured this cycle.
REQ-015 write_finish  output  1  one-cycle pulse: write-back committed.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 Line SHALL be 4 x 64-bit words; word index = addr[3 +: log2(DEPTH_WORDS)]; line base = that index with bits [1:0] cleared; out-of-range addresses SHALL wrap modulo DEPTH_WORDS; addr[2:0] SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, RD_WAIT, RD_BURST, RD_DONE, WB_DATA, WB_WAIT and WB_DONE.
REQ-019 Requests SHALL be sampled only in IDLE; accept cycle T = the IDLE cycle in which a request is high.
REQ-020 When wb_req and refill_req are both high in IDLE, the write-back SHALL be accepted first; the refill SHALL be accepted in the first IDLE cycle after write_finish.
REQ-021 Refill: RD_WAIT SHALL last LATENCY cycles, then RD_BURST SHALL assert refill_valid for exactly 4 consecutive cycles, the first at T+1+LATENCY.
REQ-022 Refill: refilled SHALL pulse in the cycle after the last beat (RD_DONE), then the FSM SHALL return to IDLE.
REQ-023 Refill beat order SHALL be 0,1,2,3 unless REFILL_CWF_EN is defined.
REQ-024 Write-back: wb_data_ready SHALL be high for cycles T+1..T+4, capturing beats 0..3 into line words 0..3 of the wb_addr line, written as each beat arrives.
REQ-025 Write-back: WB_WAIT SHALL last LATENCY cycles after the last beat, then write_finish SHALL pulse for one cycle (WB_DONE), then the FSM SHALL return to IDLE.
REQ-026 A refill accepted after a write-back to the same line SHALL return the written data.
REQ-027 The wait counter SHALL be 4 bits; with LATENCY=0, RD_WAIT/WB_WAIT SHALL be skipped (0 cycles).
REQ-028 A request still high in the IDLE cycle after refilled or write_finish SHALL be treated as a new request.
REQ-029 refill_data SHALL be 0 whenever refill_valid=0.
REQ-030 Address inputs SHALL be latched at acceptance; later changes SHALL be ignored until the next IDLE.

Reset
REQ-031 While rst=1 at a clock edge, the FSM SHALL enter IDLE, and all outputs SHALL be 0 in the next cycle.
REQ-032 Reset mid-operation SHALL abort the transaction with no refilled or write_finish pulse; already-written beats SHALL remain in storage.
REQ-033 Reset SHALL NOT clear storage contents.

Configuration
REQ-034 With REFILL_CWF_EN defined, refill beats SHALL start at refill_addr[4:3] and wrap (e.g. offset 2: beats 2,3,0,1); refill_beat SHALL report each word's true index.
REQ-035 Without REFILL_CWF_EN, refill beat order SHALL be 0,1,2,3 regardless of refill_addr[4:3].

Verification
REQ-036 LATENCY=4; refill_req at T, addr 0x40, mem[8..11]=A0..A3 -> refill_valid at T+5..T+8 with beats 0..3 = A0..A3; refilled at T+9; busy low at T+10.
REQ-037 wb_req at T, addr 0x80, write_data D0..D3 on T+1..T+4 -> wb_data_ready at T+1..T+4; write_finish at T+9; a refill of 0x80 then returns D0..D3.
REQ-038 wb_req and refill_req both high at T (same line 0x100) -> write-back completes first; the refill then returns the new data.
REQ-039 REFILL_CWF_EN defined, refill addr 0x50 (offset 2) -> refill_beat sequence 2,3,0,1 with matching data.
REQ-040 rst pulsed during the RD_BURST beat 1 cycle -> all outputs 0 next cycle; no refilled pulse; a new refill is then accepted normally.
REQ-041 LATENCY=0, refill at T -> refill_valid at T+1..T+4; refilled at T+5.
